spi_fsm: RTL and testbench

SPI_FSM -- requirements
Module: spi_fsm

---
 rtl/spi_fsm_pkg.sv | 27 ++
 rtl/spi_bit_counter.sv | 31 +++
 rtl/spi_fsm.sv | 162 ++++++++++++++++
 tb/tb_spi_fsm.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_fsm_pkg.sv
// Shared types and defaults for the SPI slave sequencing FSM.
// Holds the state encoding, parameter defaults and the bit-counter width rule.
package spi_fsm_pkg;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_GET         = 4'd1,
        ST_GOT         = 4'd2,
        ST_READ_LOAD   = 4'd3,
        ST_READ_SR     = 4'd4,
        ST_READ_OUT    = 4'd5,
        ST_WRITE_SHIFT = 4'd6,
        ST_WRITE_MEM   = 4'd7,
        ST_DONE        = 4'd8
    } state_t;

    localparam int BYTE_BITS_DEF  = 8;
    localparam int ADDR_WIDTH_DEF = 7;

    // Wide enough to hold BYTE_BITS itself so the count can saturate rather than wrap.
    function automatic int cnt_width(input int bits);
        return $clog2(bits + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(BYTE_BITS_DEF);

endpackage

// File: rtl/spi_bit_counter.sv
// Per-phase SCLK edge counter with synchronous clear and saturation at BYTE_BITS.
// done_o flags the increment that completes the phase.
module spi_bit_counter
    import spi_fsm_pkg::*;
#(
    parameter int BYTE_BITS = BYTE_BITS_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic done_o
);

    localparam int CNT_W = cnt_width(BYTE_BITS);

    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        done_o = inc_i && (cnt_q == CNT_W'(BYTE_BITS - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != CNT_W'(BYTE_BITS))) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_fsm.sv
// SPI slave transaction sequencer: address byte, then a read or write data byte.
// Optional idle-SCLK abort is built only when SPI_FSM_TIMEOUT_EN is defined.
//
// state        | meaning
// IDLE         | waiting for a chip-select falling edge
// GET          | shifting in the address/rw byte on SCLK rising edges
// GOT          | latching the address (addr_we)
// READ_LOAD    | one cycle of data-memory read latency
// READ_SR      | loading read data into the shift register (sr_we)
// READ_OUT     | driving MISO, counting SCLK falling edges
// WRITE_SHIFT  | shifting in write data on SCLK rising edges
// WRITE_MEM    | committing the write byte (dm_we)
// DONE         | transaction complete, waiting for chip select to rise
module spi_fsm
    import spi_fsm_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int BYTE_BITS      = BYTE_BITS_DEF,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic cs_cond,
    input  logic sclk_posedge,
    input  logic sclk_negedge,
    input  logic rw_bit,
    output logic addr_we,
    output logic sr_we,
    output logic dm_we,
    output logic miso_buff_en,
    output logic busy,
    output logic timeout_err
);

    if (ADDR_WIDTH < 1 || BYTE_BITS < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("spi_fsm: invalid parameter value");
    end

    state_t state_q, state_d;
    logic   cs_q;
    logic   addr_we_q, sr_we_q, dm_we_q, miso_buff_en_q, busy_q;
    logic   cnt_clr, cnt_inc, cnt_done;
    logic   to_hit;

    spi_bit_counter #(
        .BYTE_BITS (BYTE_BITS)
    ) u_bit_counter (
        .clk_i  (clk),
        .rst_i  (reset),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .done_o (cnt_done)
    );

    // Each counting state honours only its own edge; chip-select high suppresses counting.
    always_comb begin
        cnt_inc = 1'b0;
        if (!cs_cond) begin
            unique case (state_q)
                ST_GET, ST_WRITE_SHIFT: cnt_inc = sclk_posedge;
                ST_READ_OUT:            cnt_inc = sclk_negedge;
                default:                cnt_inc = 1'b0;
            endcase
        end
    end

`ifdef SPI_FSM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_err_q;
    logic            timed;

    always_comb begin
        timed  = (state_q == ST_GET) || (state_q == ST_READ_OUT) || (state_q == ST_WRITE_SHIFT);
        to_hit = timed && !cs_cond && !cnt_inc && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    end

    assign timeout_err = timeout_err_q;
`else
    always_comb begin
        to_hit = 1'b0;
    end

    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        if (state_q != ST_IDLE && cs_cond) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cs_q && !cs_cond) begin
                        state_d = ST_GET;
                        cnt_clr = 1'b1;
                    end
                end
                ST_GET:         if (cnt_done) state_d = ST_GOT;
                ST_GOT: begin
                    state_d = rw_bit ? ST_READ_LOAD : ST_WRITE_SHIFT;
                    cnt_clr = 1'b1;
                end
                ST_READ_LOAD:   state_d = ST_READ_SR;
                ST_READ_SR: begin
                    state_d = ST_READ_OUT;
                    cnt_clr = 1'b1;
                end
                ST_READ_OUT:    if (cnt_done) state_d = ST_DONE;
                ST_WRITE_SHIFT: if (cnt_done) state_d = ST_WRITE_MEM;
                ST_WRITE_MEM:   state_d = ST_DONE;
                ST_DONE:        if (cs_cond) state_d = ST_IDLE;
                default:        state_d = ST_IDLE;
            endcase
            if (to_hit) begin
                state_d = ST_DONE;
            end
        end
    end

    // Outputs are decoded from the next state so each register mirrors the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cs_q           <= 1'b0;
            addr_we_q      <= 1'b0;
            sr_we_q        <= 1'b0;
            dm_we_q        <= 1'b0;
            miso_buff_en_q <= 1'b0;
            busy_q         <= 1'b0;
`ifdef SPI_FSM_TIMEOUT_EN
            to_cnt_q       <= '0;
            timeout_err_q  <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cs_q           <= cs_cond;
            addr_we_q      <= (state_d == ST_GOT);
            sr_we_q        <= (state_d == ST_READ_SR);
            dm_we_q        <= (state_d == ST_WRITE_MEM);
            miso_buff_en_q <= (state_d == ST_READ_OUT);
            busy_q         <= (state_d != ST_IDLE);
`ifdef SPI_FSM_TIMEOUT_EN
            if (!timed || cnt_inc || (state_d != state_q)) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
            timeout_err_q  <= to_hit;
`endif
        end
    end

    assign addr_we      = addr_we_q;
    assign sr_we        = sr_we_q;
    assign dm_we        = dm_we_q;
    assign miso_buff_en = miso_buff_en_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_spi_fsm.sv
// Directed bench for spi_fsm: read, write, abort, reset and idle-SCLK scenarios.
// Output vector order: {addr_we, sr_we, dm_we, miso_buff_en, busy, timeout_err}.
module tb_spi_fsm;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cs_cond = 1'b1;
    logic sclk_posedge = 1'b0;
    logic sclk_negedge = 1'b0;
    logic rw_bit = 1'b0;
    logic addr_we, sr_we, dm_we, miso_buff_en, busy, timeout_err;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_BUSY  = 6'b000010;
    localparam logic [5:0] O_GOT   = 6'b100010;
    localparam logic [5:0] O_SR    = 6'b010010;
    localparam logic [5:0] O_RDOUT = 6'b000110;
    localparam logic [5:0] O_WMEM  = 6'b001010;
    localparam logic [5:0] O_TOUT  = 6'b000011;

    spi_fsm #(
        .ADDR_WIDTH     (7),
        .BYTE_BITS      (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cs_cond      (cs_cond),
        .sclk_posedge (sclk_posedge),
        .sclk_negedge (sclk_negedge),
        .rw_bit       (rw_bit),
        .addr_we      (addr_we),
        .sr_we        (sr_we),
        .dm_we        (dm_we),
        .miso_buff_en (miso_buff_en),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {addr_we, sr_we, dm_we, miso_buff_en, busy, timeout_err};
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic pos_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            sclk_posedge = 1'b1;
            tick();
            sclk_posedge = 1'b0;
        end
    endtask

    task automatic neg_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            sclk_negedge = 1'b1;
            tick();
            sclk_negedge = 1'b0;
        end
    endtask

    initial begin
        // Reset, then release with chip select high so cs_q sees it.
        tick();
        tick();
        chk("reset_outputs", O_IDLE);
        reset = 1'b0;
        tick();
        chk("idle_after_reset", O_IDLE);

        // Read transaction with a coincident edge and a stray posedge in READ_OUT.
        rw_bit = 1'b1;
        cs_cond = 1'b0;
        tick();
        chk("rd_enter_get", O_BUSY);
        pos_pulses(7);
        chk("rd_get_after7", O_BUSY);
        sclk_negedge = 1'b1;
        tick();
        sclk_negedge = 1'b0;
        chk("rd_get_ignores_neg", O_BUSY);
        pos_pulses(1);
        chk("rd_got_addr_we", O_GOT);
        tick();
        chk("rd_read_load", O_BUSY);
        tick();
        chk("rd_read_sr", O_SR);
        tick();
        chk("rd_read_out_entry", O_RDOUT);
        sclk_posedge = 1'b1;
        sclk_negedge = 1'b1;
        tick();
        sclk_posedge = 1'b0;
        sclk_negedge = 1'b0;
        chk("rd_coincident_once", O_RDOUT);
        pos_pulses(2);
        chk("rd_ignores_pos", O_RDOUT);
        neg_pulses(6);
        chk("rd_after7_neg", O_RDOUT);
        neg_pulses(1);
        chk("rd_done", O_BUSY);
        tick();
        chk("rd_done_hold", O_BUSY);
        cs_cond = 1'b1;
        tick();
        chk("rd_idle", O_IDLE);

        // Write transaction.
        rw_bit = 1'b0;
        cs_cond = 1'b0;
        tick();
        chk("wr_enter_get", O_BUSY);
        pos_pulses(8);
        chk("wr_got_addr_we", O_GOT);
        tick();
        chk("wr_shift_entry", O_BUSY);
        pos_pulses(4);
        neg_pulses(3);
        pos_pulses(3);
        chk("wr_shift_after7", O_BUSY);
        pos_pulses(1);
        chk("wr_mem_dm_we", O_WMEM);
        tick();
        chk("wr_done", O_BUSY);
        cs_cond = 1'b1;
        tick();
        chk("wr_idle", O_IDLE);

        // Abort in WRITE_SHIFT: cs high wins over a coincident posedge.
        cs_cond = 1'b0;
        tick();
        pos_pulses(8);
        chk("ab_got", O_GOT);
        tick();
        pos_pulses(5);
        chk("ab_shift_after5", O_BUSY);
        cs_cond = 1'b1;
        sclk_posedge = 1'b1;
        tick();
        sclk_posedge = 1'b0;
        chk("ab_idle", O_IDLE);
        tick();
        chk("ab_idle_hold", O_IDLE);

        // Reset mid-GET with cs held low: no restart until cs is seen high.
        cs_cond = 1'b0;
        tick();
        chk("rs_get", O_BUSY);
        pos_pulses(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_reset_idle", O_IDLE);
        tick();
        tick();
        tick();
        chk("rs_idle_held", O_IDLE);
        cs_cond = 1'b1;
        tick();
        chk("rs_cs_high", O_IDLE);
        cs_cond = 1'b0;
        tick();
        chk("rs_restart_get", O_BUSY);

        // Stall in GET after 3 posedges.
        pos_pulses(3);
`ifdef SPI_FSM_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) begin
            tick();
        end
        chk("to_no_pulse_before_16", O_BUSY);
        tick();
        chk("to_pulse_cycle16", O_TOUT);
        tick();
        chk("to_done_after_pulse", O_BUSY);
`else
        for (int k = 1; k <= 20; k++) begin
            tick();
        end
        chk("to_disabled_stays_get", O_BUSY);
        pos_pulses(5);
        chk("to_disabled_resume_got", O_GOT);
`endif
        cs_cond = 1'b1;
        tick();
        chk("end_idle", O_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
